tcs3200_freq_scanner: RTL

Front end of the colour-sensing path. It drives the TCS3200 filter-select lines S2/S3 through red, green and blue, and lets the sensor output settle after each switch. It then counts rising edges of the sensor's square-wave output over a fixed gate window and publishes one coherent red/green/blue count set per frame. Its outputs feed the normalisation and colour-identification stage directly.

---
 rtl/tcs3200_freq_scanner.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tcs3200_freq_scanner.sv
// TCS3200 colour front end: steps the S2/S3 filter through red, green and blue,
// counts sensor edges over a gate window per channel and publishes one coherent RGB set per frame.
module tcs3200_freq_scanner #(
    parameter int SETTLE_CYCLES = 5000,
    parameter int GATE_CYCLES   = 500000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sensor_out,
    output logic [1:0]       s2_s3,
    output logic             led_en,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt,
    output logic             overflow,
    output logic             sample_valid,
    output logic             busy
);

    localparam int CYC_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [CYC_W-1:0] GATE_LAST   = CYC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, LATCH} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   redSh_q, redSh_d, greenSh_q, greenSh_d, blueSh_q, blueSh_d;
    logic               redSat_q, redSat_d, greenSat_q, greenSat_d, blueSat_q, blueSat_d;
    logic [CNT_W-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               sync1_q, sync2_q, prev_q;

    logic               edgePulse;
    logic               edgeAtMax;
    logic [CNT_W-1:0]   finalCnt;
    logic               finalSat;

    // Synchronizer and edge detector run in every state so IDLE exit sees no stale edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sensor_out;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign edgePulse = sync2_q & ~prev_q;
    assign edgeAtMax = (edge_q == CNT_MAX);
    assign finalCnt  = (edgePulse && !edgeAtMax) ? edge_q + 1'b1 : edge_q;
    assign finalSat  = sat_q | (edgePulse & edgeAtMax);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= 2'd0;
            cyc_q      <= '0;
            edge_q     <= '0;
            sat_q      <= 1'b0;
            redSh_q    <= '0;
            greenSh_q  <= '0;
            blueSh_q   <= '0;
            redSat_q   <= 1'b0;
            greenSat_q <= 1'b0;
            blueSat_q  <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cyc_q      <= cyc_d;
            edge_q     <= edge_d;
            sat_q      <= sat_d;
            redSh_q    <= redSh_d;
            greenSh_q  <= greenSh_d;
            blueSh_q   <= blueSh_d;
            redSat_q   <= redSat_d;
            greenSat_q <= greenSat_d;
            blueSat_q  <= blueSat_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cyc_d      = cyc_q;
        edge_d     = edge_q;
        sat_d      = sat_q;
        redSh_d    = redSh_q;
        greenSh_d  = greenSh_q;
        blueSh_d   = blueSh_q;
        redSat_d   = redSat_q;
        greenSat_d = greenSat_q;
        blueSat_d  = blueSat_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        case (state_q)
            IDLE: begin
                ch_d  = 2'd0;
                cyc_d = '0;
                if (enable) state_d = SETTLE;
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                    state_d = GATE;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            GATE: begin
                if (!enable) begin
                    state_d = IDLE;
                    cyc_d   = '0;
                end else begin
                    edge_d = finalCnt;
                    sat_d  = finalSat;
                    if (cyc_q == GATE_LAST) begin
                        // The terminal-cycle edge is folded into the stored count.
                        cyc_d = '0;
                        case (ch_q)
                            2'd0: begin
                                redSh_d  = finalCnt;
                                redSat_d = finalSat;
                            end
                            2'd1: begin
                                greenSh_d  = finalCnt;
                                greenSat_d = finalSat;
                            end
                            default: begin
                                blueSh_d  = finalCnt;
                                blueSat_d = finalSat;
                            end
                        endcase
                        if (ch_q < 2'd2) begin
                            ch_d    = ch_q + 2'd1;
                            state_d = SETTLE;
                        end else begin
                            state_d = LATCH;
                        end
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            LATCH: begin
                red_d   = redSh_q;
                green_d = greenSh_q;
                blue_d  = blueSh_q;
                ovf_d   = redSat_q | greenSat_q | blueSat_q;
                valid_d = 1'b1;
                ch_d    = 2'd0;
                cyc_d   = '0;
                state_d = enable ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Filter codes: red 00, green 11, blue 01; parked on red while idle.
    always_comb begin
        s2_s3 = 2'b00;
        if (state_q != IDLE) begin
            case (ch_q)
                2'd1:    s2_s3 = 2'b11;
                2'd2:    s2_s3 = 2'b01;
                default: s2_s3 = 2'b00;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign led_en       = busy;
    assign red_cnt      = red_q;
    assign green_cnt    = green_q;
    assign blue_cnt     = blue_q;
    assign overflow     = ovf_q;
    assign sample_valid = valid_q;

endmodule
